// File: rtl/z_drain.sv
// z_drain: Z-result FIFO to register-file writeback; pushed data is visible the cycle after push.
// Backpressure: wb_ack gates pop; a push while full without pop is dropped and sets sticky overflow. Z_DRAIN_BYPASS_EN adds same-cycle empty bypass.
module z_drain #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctr,
  input  logic [31:0]   data_in,
  output logic          wb_valid,
  output logic [31:0]   wb_data,
  input  logic          wb_ack,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop, store;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign overflow = ovf_q;

  // pop only ever retires a stored entry; a bypassed value never touches the array
  assign pop = !empty && wb_ack;

`ifdef Z_DRAIN_BYPASS_EN
  assign wb_valid = !empty || ctr;
  assign wb_data  = !empty ? mem_q[rptr_q] : (ctr ? data_in : 32'h0);
  assign store    = ctr && (!full || pop) && !(empty && wb_ack);
`else
  assign wb_valid = !empty;
  assign wb_data  = !empty ? mem_q[rptr_q] : 32'h0;
  assign store    = ctr && (!full || pop);
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (store) wptr_d = wptr_q + PTR_ONE;
    if (pop)   rptr_d = rptr_q + PTR_ONE;
    if (store && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !store) count_d = count_q - CNT_ONE;
    if (ctr && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Array contents are don't-care after reset: empty masks wb_data to zero.
  always_ff @(posedge clk) begin
    if (store && !rst) mem_q[wptr_q] <= data_in;
  end

endmodule

// File: tb/tb_z_drain.sv
// Bench for z_drain: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_z_drain;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctr;
  logic [31:0]   data_in;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic          wb_ack;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  bit          m_ovf;

  z_drain #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ctr(ctr), .data_in(data_in),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_ack(wb_ack),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic exp_valid(input logic c);
`ifdef Z_DRAIN_BYPASS_EN
    return (mq.size() != 0) || c;
`else
    return (mq.size() != 0);
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic c, input logic [31:0] d);
    if (mq.size() != 0) return mq[0];
`ifdef Z_DRAIN_BYPASS_EN
    if (c) return d;
`endif
    return 32'h0;
  endfunction

  function automatic void model_step(input logic c, input logic [31:0] d, input logic a);
    int n;
    bit p;
    n = mq.size();
    p = exp_valid(c) && a;
`ifdef Z_DRAIN_BYPASS_EN
    if (n == 0 && c && a) return;
`endif
    if (p) void'(mq.pop_front());
    if (c) begin
      if (n < DEPTH || p) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  // One clock of stimulus; returns at posedge+2 with inputs idle.
  task automatic cyc(input logic c, input logic [31:0] d, input logic a);
    ctr = c; data_in = d; wb_ack = a;
    @(posedge clk);
    model_step(c, d, a);
    #1;
    ctr = 1'b0; wb_ack = 1'b0; data_in = 32'h0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ctr = 1'b1; wb_ack = 1'b1; data_in = 32'h1234;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)      begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    ctr = 1'b0; wb_ack = 1'b0; data_in = 32'h0;
    #1;
    checks++; if (wb_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 32'h0)  begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_first_push();
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    checks++; if (wb_valid !== 1'b1)        begin failures++; $display("FAIL first_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL first_data got=%h exp=deadbeef", wb_data); end
    checks++; if (count !== 3'd1)           begin failures++; $display("FAIL first_count got=%0d exp=1", count); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL fill_full full=%b count=%0d exp full=1 count=4", full, count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
    cyc(1'b1, 32'd5, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL ovf_set ovf=%b count=%0d exp ovf=1 count=4", overflow, count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'(i)) begin failures++; $display("FAIL drain_%0d valid=%b data=%0d exp valid=1 data=%0d", i, wb_valid, wb_data, i); end
      cyc(1'b0, 32'h0, 1'b1);
    end
    checks++; if (empty !== 1'b1 || wb_data !== 32'h0) begin failures++; $display("FAIL drain_empty empty=%b data=%h exp empty=1 data=0", empty, wb_data); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    cyc(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL ack_empty count=%0d empty=%b exp 0/1", count, empty); end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b1, 32'd9, 1'b1);
    checks++; if (count !== 3'd4 || full !== 1'b1) begin failures++; $display("FAIL pp_count count=%0d full=%b exp 4/1", count, full); end
    checks++; if (wb_data !== 32'd2) begin failures++; $display("FAIL pp_head got=%0d exp=2", wb_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
    foreach (mq[k]) begin
      checks++; if (wb_data !== mq[0]) begin failures++; $display("FAIL pp_drain got=%0d exp=%0d", wb_data, mq[0]); end
      cyc(1'b0, 32'h0, 1'b1);
    end
    checks++; if (mq.size() != 0 || empty !== 1'b1) begin failures++; $display("FAIL pp_final empty=%b model=%0d exp empty", empty, mq.size()); end
  endtask

  task automatic test_wrap();
    int pops;
    logic [31:0] expv[$];
    logic [31:0] got;
    do_reset();
    cyc(1'b1, 32'h10, 1'b0);
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h12, 1'b0);
    for (int i = 0; i < 3; i++) expv.push_back(32'h10 + 32'(i));
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      got = wb_data;
      checks++; if (got !== expv[0]) begin failures++; $display("FAIL wrap_order_%0d got=%h exp=%h", i, got, expv[0]); end
      void'(expv.pop_front());
      if (i < 3) begin
        expv.push_back(32'h13 + 32'(i));
        cyc(1'b1, 32'h13 + 32'(i), 1'b1);
      end else cyc(1'b0, 32'h0, 1'b1);
      pops++;
    end
    checks++; if (count !== 3'd0 || pops != 6) begin failures++; $display("FAIL wrap_end count=%0d exp=0", count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd3 || overflow !== 1'b1) begin failures++; $display("FAIL ar_pre count=%0d ovf=%b exp 3/1", count, overflow); end
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || wb_valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ar_immediate count=%0d valid=%b ovf=%b exp 0/0/0", count, wb_valid, overflow); end
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 32'h7, 1'b0);
    checks++; if (wb_data !== 32'h7 || count !== 3'd1) begin failures++; $display("FAIL ar_post data=%h count=%0d exp 7/1", wb_data, count); end
  endtask

`ifdef Z_DRAIN_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    ctr = 1'b1; data_in = 32'hA5; wb_ack = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hA5) begin failures++; $display("FAIL byp_same valid=%b data=%h exp 1/a5", wb_valid, wb_data); end
    @(posedge clk);
    model_step(1'b1, 32'hA5, 1'b1);
    #1;
    ctr = 1'b0; wb_ack = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL byp_count got=%0d exp=0", count); end
  endtask
`endif

  task automatic test_random();
    logic        c, a;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 70 : 35));
      a = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 35 : 70));
      d = $urandom;
      ctr = c; data_in = d; wb_ack = a;
      #1;
      checks++; if (wb_valid !== exp_valid(c) || wb_data !== exp_data(c, d)) begin
        failures++; $display("FAIL rnd_out_%0d valid=%b data=%h exp %b/%h", i, wb_valid, wb_data, exp_valid(c), exp_data(c, d));
      end
      @(posedge clk);
      model_step(c, d, a);
      #1;
      checks++; if (count !== (AW+1)'(mq.size()) || full !== (mq.size() == DEPTH) ||
                    empty !== (mq.size() == 0) || overflow !== m_ovf) begin
        failures++; $display("FAIL rnd_state_%0d count=%0d full=%b empty=%b ovf=%b exp %0d/%b/%b/%b",
                             i, count, full, empty, overflow, mq.size(), mq.size() == DEPTH, mq.size() == 0, m_ovf);
      end
    end
    ctr = 1'b0; wb_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctr = 1'b0; wb_ack = 1'b0; data_in = 32'h0;
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_full_pushpop();
    test_wrap();
    test_async_reset();
`ifdef Z_DRAIN_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z_drain.md
Z_DRAIN -- requirements
Module: z_drain

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered 32-bit result entries (power of two, 2..16).
REQ-002 Parameter: AW, 2, pointer width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ctr  input  1  write strobe from the Z-register control; high = capture data_in this edge.
REQ-006 data_in  input  32  ALU result to buffer.
REQ-007 wb_valid  output  1  head entry available for register-file writeback.
REQ-008 wb_data  output  32  head entry value; 32'h0 when wb_valid=0.
REQ-009 wb_ack  input  1  writeback consumer accepts head this edge.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag; a write was dropped.

Function
REQ-014 The block SHALL store entries in a circular buffer with write pointer and read pointer, each AW bits, wrapping DEPTH-1 -> 0.
REQ-015 Push SHALL occur at a clk edge when ctr=1 and (full=0 or pop occurs the same edge).
REQ-016 Pop SHALL occur at a clk edge when wb_valid=1 and wb_ack=1.
REQ-017 wb_valid SHALL equal !empty (non-bypass build); wb_data SHALL be the entry at the read pointer, registered-array read, no added cycle.
REQ-018 Latency: data pushed at edge N SHALL be visible on wb_data/wb_valid after edge N when the buffer was empty.
REQ-019 Simultaneous push and pop SHALL both take effect; count unchanged; legal at full and at any non-empty level.
REQ-020 ctr=1 while full with no pop: data_in SHALL be discarded, contents/pointers unchanged, overflow set to 1 at that edge.
REQ-021 overflow SHALL remain 1 until rst; no other clear path.
REQ-022 wb_ack while empty (non-bypass) SHALL be ignored: no pointer move, count stays 0.
REQ-023 Order SHALL be strict FIFO; no entry reordered, duplicated, or lost except per REQ-020.
REQ-024 count, full, empty SHALL be registered-state-derived, glitch-free relative to clk.

Reset
REQ-025 rst=1 SHALL immediately (without clk) clear pointers, count=0, overflow=0, giving empty=1, full=0, wb_valid=0, wb_data=32'h0.
REQ-026 rst asserted mid-operation SHALL discard all stored entries; array contents need not be cleared.
REQ-027 While rst=1, ctr and wb_ack SHALL have no effect.
REQ-028 First push SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-029 Macro Z_DRAIN_BYPASS_EN, when defined, SHALL add a combinational bypass: when empty=1 and ctr=1, wb_valid=1 and wb_data=data_in in the same cycle.
REQ-030 With Z_DRAIN_BYPASS_EN and bypass active, wb_ack=1 at that edge SHALL consume the value without storing it (count stays 0); wb_ack=0 SHALL store it normally.
REQ-031 Without Z_DRAIN_BYPASS_EN, wb_valid SHALL depend only on registered state and the empty-cycle behaviour SHALL follow REQ-017/REQ-022.

Verification
REQ-032 Reset then ctr=1 data_in=32'hDEADBEEF one cycle, wb_ack=0 -> next cycle wb_valid=1, wb_data=32'hDEADBEEF, count=1.
REQ-033 Push 1,2,3,4 with wb_ack=0 -> full=1, count=4; push 5 -> overflow=1, count=4; drain with wb_ack=1 -> 1,2,3,4 in order, then empty=1, wb_data=0.
REQ-034 At full, ctr=1 data_in=9 and wb_ack=1 same edge -> count=4, head advances, 9 emerges last; overflow unchanged.
REQ-035 Push 6 entries interleaved with 6 acks across pointer wrap -> values emerge in push order, no loss, count returns to 0.
REQ-036 Load 3 entries, assert rst between clk edges -> count=0, wb_valid=0, overflow=0 immediately; push 32'h7 after release -> wb_data=32'h7.
REQ-037 With Z_DRAIN_BYPASS_EN: empty, ctr=1 data_in=32'hA5, wb_ack=1 -> wb_valid=1, wb_data=32'hA5 same cycle, count=0 after edge.
